// File: rtl/ling_mp_add_seq_if.sv
// rtl/ling_mp_add_seq_if.sv - limb stream in / sum stream out bundle for ling_mp_add_seq
interface ling_mp_add_seq_if #(
  parameter int N    = 64,
  parameter int IDXW = 4
) ();
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic            in_cin;
  logic            in_first;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_sum;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            out_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_idx, out_last, out_cout
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_idx, out_last, out_cout
  );
endinterface

// File: rtl/ling_mp_add_seq.sv
// rtl/ling_mp_add_seq.sv - multi-precision add sequencer around the 64-bit Ling adder
module ling_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);
  logic [63:0] g;
  logic [63:0] t;
  logic [63:0] tp;
  logic [64:0] h;
  logic [64:0] c;

  assign g  = a & b;
  assign t  = a | b;
  assign tp = {t[62:0], 1'b1};

  // Ling pseudo-carry h[i+1] = g[i] | t[i-1]&h[i]; real carry recovered as t[i]&h[i+1]
  always_comb begin
    h    = '0;
    c    = '0;
    h[0] = cin;
    c[0] = cin;
    for (int i = 0; i < 64; i++) begin
      h[i+1] = g[i] | (tp[i] & h[i]);
      c[i+1] = t[i] & h[i+1];
    end
    s    = a ^ b ^ c[63:0];
    cout = c[64];
  end
endmodule

module ling_mp_add_seq #(
  parameter int N         = 64,
  parameter int MAX_LIMBS = 16,
  parameter int IDXW      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ling_mp_add_seq_if.slave       bus,
  output logic                   proto_err,
  output logic                   ovf
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDXW-1:0] IDX_MAX = {IDXW{1'b1}};
  localparam logic [IDXW:0]   CNT_LIM = MAX_LIMBS[IDXW:0];

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            wrap_q, wrap_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_sum_q, out_sum_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            out_cout_q, out_cout_d;
  logic            proto_err_q, proto_err_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            restart;
  logic            add_cin;
  logic [N-1:0]    add_s;
  logic            add_cout;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign restart      = (state_q == IDLE) | bus.in_first;
  assign add_cin      = restart ? bus.in_cin : carry_q;

  ling_64 u_add (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    wrap_d      = wrap_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    proto_err_d = proto_err_q;
    ovf_d       = ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_s;
      if (restart) begin
        out_idx_d = '0;
        idx_d     = {{(IDXW-1){1'b0}}, 1'b1};
        wrap_d    = 1'b0;
        // first-less start from IDLE and mid-operation restart are both protocol faults
        if ((state_q == IDLE) != bus.in_first) begin
          proto_err_d = 1'b1;
        end
      end else begin
        out_idx_d = idx_q;
        if (idx_q == IDX_MAX) begin
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        // wrap_q extends the saturated index so limbs past 2^IDXW still count
        if ({wrap_q, idx_q} >= CNT_LIM) begin
          ovf_d = 1'b1;
        end
      end
      if (bus.in_last) begin
        out_last_d = 1'b1;
        out_cout_d = add_cout;
        carry_d    = 1'b0;
        state_d    = IDLE;
      end else begin
        out_last_d = 1'b0;
        out_cout_d = 1'b0;
        carry_d    = add_cout;
        state_d    = RUN;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      proto_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      proto_err_q <= proto_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign proto_err     = proto_err_q;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_ling_mp_add_seq.sv
// tb/tb_ling_mp_add_seq.sv - scoreboard bench for ling_mp_add_seq
module tb_ling_mp_add_seq;
  typedef struct packed {
    logic [63:0] sum;
    logic [3:0]  idx;
    logic        last;
    logic        cout;
  } exp_t;

  logic clk;
  logic rst_n;
  logic proto_err;
  logic ovf;

  int checks;
  int errors;

  exp_t        sb[$];
  logic [63:0] obs_log[$];
  logic        obs_cout;

  logic        m_run;
  logic        m_carry;
  int          m_idx;

  ling_mp_add_seq_if #(.N(64), .IDXW(4)) ifc ();

  ling_mp_add_seq #(.N(64), .MAX_LIMBS(16), .IDXW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .proto_err (proto_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run   = 1'b0;
    m_carry = 1'b0;
    m_idx   = 0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input logic first, input logic last);
    exp_t        e;
    logic [64:0] full;
    logic        c;
    bit          restart;
    bit          got;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_cin   = cin;
    ifc.in_first = first;
    ifc.in_last  = last;
    ifc.in_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", {63'd0, ifc.in_ready}, 64'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    restart = !m_run || first;
    c       = restart ? cin : m_carry;
    full    = {1'b0, a} + {1'b0, b} + {64'd0, c};
    e.sum   = full[63:0];
    e.idx   = restart ? 4'd0 : m_idx[3:0];
    e.last  = last;
    e.cout  = last ? full[64] : 1'b0;
    sb.push_back(e);
    if (restart) m_idx = 1;
    else if (m_idx < 15) m_idx = m_idx + 1;
    m_run   = !last;
    m_carry = last ? 1'b0 : full[64];
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("out_sum",  ifc.out_sum, e.sum);
        chk("out_idx",  {60'd0, ifc.out_idx}, {60'd0, e.idx});
        chk("out_last", {63'd0, ifc.out_last}, {63'd0, e.last});
        chk("out_cout", {63'd0, ifc.out_cout}, {63'd0, e.cout});
        obs_log.push_back(ifc.out_sum);
        if (ifc.out_last) obs_cout = ifc.out_cout;
      end
    end
  end

  initial begin
    logic [255:0] A;
    logic [255:0] B;
    logic [256:0] ref_sum;
    logic [63:0]  stall_exp;
    checks       = 0;
    errors       = 0;
    obs_cout     = 1'b0;
    model_clear();
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_a     = '0;
    ifc.in_b     = '0;
    ifc.in_cin   = 1'b0;
    ifc.in_first = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_out_sum",   ifc.out_sum, 64'd0);
    chk("rst_out_idx",   {60'd0, ifc.out_idx}, 64'd0);
    chk("rst_out_last",  {63'd0, ifc.out_last}, 64'd0);
    chk("rst_out_cout",  {63'd0, ifc.out_cout}, 64'd0);
    chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
    chk("rst_ovf",       {63'd0, ovf}, 64'd0);
    chk("rst_in_ready",  {63'd0, ifc.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single limb with carry out
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1);
    // two-limb carry chain
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
    send(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    // back-to-back: op A carries out, op B must start from its own cin
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    send(64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
    send(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    drain();

    // 256-bit add with a 3-cycle downstream stall after limb 1
    for (int i = 0; i < 8; i++) begin
      A[32*i +: 32] = $urandom;
      B[32*i +: 32] = $urandom;
    end
    A[255:192] = 64'hFFFF_FFFF_FFFF_FFFF;
    ref_sum = {1'b0, A} + {1'b0, B};
    obs_log.delete();
    send(A[63:0], B[63:0], 1'b0, 1'b1, 1'b0);
    send(A[127:64], B[127:64], 1'b0, 1'b0, 1'b0);
    ifc.out_ready = 1'b0;
    stall_exp     = ref_sum[127:64];
    ifc.in_a      = A[191:128];
    ifc.in_b      = B[191:128];
    ifc.in_first  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready",  {63'd0, ifc.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("stall_out_sum",   ifc.out_sum, stall_exp);
      @(posedge clk);
    end
    #1;
    ifc.out_ready = 1'b1;
    send(A[191:128], B[191:128], 1'b0, 1'b0, 1'b0);
    send(A[255:192], B[255:192], 1'b0, 1'b0, 1'b1);
    drain();
    chk("wide_limb_count", obs_log.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_log.size()) chk("wide_limb", obs_log[i], ref_sum[64*i +: 64]);
    end
    chk("wide_cout", {63'd0, obs_cout}, {63'd0, ref_sum[256]});

    // restart while RUN
    chk("pre_proto_err", {63'd0, proto_err}, 64'd0);
    send(64'd9, 64'd9, 1'b1, 1'b1, 1'b0);
    send(64'd2, 64'd3, 1'b0, 1'b1, 1'b1);
    chk("proto_err", {63'd0, proto_err}, 64'd1);
    drain();

    // 17 limbs then asynchronous reset mid-operation
    for (int i = 0; i < 17; i++) begin
      send($urandom, $urandom, 1'b0, (i == 0), 1'b0);
      if (i == 15) chk("ovf_16", {63'd0, ovf}, 64'd0);
    end
    chk("ovf_17", {63'd0, ovf}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("mid_rst_proto_err", {63'd0, proto_err}, 64'd0);
    chk("mid_rst_ovf",       {63'd0, ovf}, 64'd0);
    sb.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0);
    send(64'd10, 64'd20, 1'b0, 1'b0, 1'b1);
    drain();
    chk("post_proto_err", {63'd0, proto_err}, 64'd0);
    chk("post_ovf",       {63'd0, ovf}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
